m_data_bridge: RTL
==================

# m_data_bridge

Memory-stage bus bridge between the pipelined datapath's single-cycle data port (address, byte enables, write data, read data) and a variable-latency request/acknowledge data bus. It registers each M-stage load or store into a bus transaction, stalls the pipeline until the bus acknowledges or a timeout expires, and returns read data to M for the data-extension logic. It sits directly downstream of the datapath's M stage and upstream of data memory and peripherals.

## Interface

- TIMEOUT, 64: cycles in WAIT without `bus_ack` before the access is abandoned; legal range 2..255.
- ERR_RDATA, 32'h0000_0000: read data returned on a timed-out or errored access.

Ports:

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- m_data_addr  in  32  M-stage byte address, word-aligned.
- m_data_byteen  in  4  store byte enables; nonzero means store.
- m_data_wdata  in  32  store data, already lane-positioned.
- m_data_ren  in  1  M-stage instruction is a load.
- m_data_rdata  out  32  read data to M stage.
- mem_stall  out  1  freeze F/D/E/M and insert a bubble into W.
- mem_err  out  1  one-cycle pulse: access timed out or bus reported an error.
- bus_req  out  1  transaction request, held until ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, `{m_data_addr[31:2],2'b00}`.
- bus_byteen  out  4  write lanes; 4'b1111 on reads.
- bus_wdata  out  32  write data.
- bus_ack  in  1  transaction complete, sampled while `bus_req`=1.
- bus_err  in  1  qualifies `bus_ack`; error response.
- bus_rdata  in  32  read data, valid with `bus_ack`.

## Operation

- Access condition: `acc = (m_data_byteen != 0) | m_data_ren`. If both are set, treat the access as a store.
- IDLE:
  - If `acc`=1, `mem_stall`=1 combinationally.
  - On the clock edge, latch address, byte enables, write data and `we`, assert `bus_req`, and go to WAIT.
  - If `acc`=0, stay in IDLE.
- WAIT:
  - `mem_stall`=1; the timeout counter increments each cycle.
  - On `bus_ack`=1:
    - Reads capture `bus_rdata`, or ERR_RDATA if `bus_err`=1.
    - Deassert `bus_req` and go to DONE.
  - If the counter reaches TIMEOUT-1 with no ack:
    - Capture ERR_RDATA, drop `bus_req`, set the error flag, and go to DONE.
- DONE:
  - `mem_stall`=0; `m_data_rdata` = captured data; `mem_err` = error flag.
  - The M instruction advances at this edge. Unconditionally return to IDLE and clear the flag and counter.
- Because of the unconditional return, a back-to-back access is seen in the following IDLE cycle. No access is ever issued twice.
- Bus fields are stable for the whole time `bus_req`=1. `bus_ack` outside WAIT is ignored.
- `m_data_rdata` holds its last captured value outside DONE.

## Timing

- Reset (asynchronous, `reset`=0):
  - State goes to IDLE.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_byteen`, `bus_wdata`, `m_data_rdata`, `mem_err`, counter all go to 0.
  - `mem_stall` is 0 while reset is asserted.
- Reset mid-WAIT drops `bus_req` immediately. There is no retry and the outstanding ack is discarded.
- Zero-wait-state bus (ack in the first WAIT cycle):
  - The M instruction occupies M for 3 cycles: IDLE/acc, WAIT, DONE.
  - 2 stall cycles.
- Each additional bus wait cycle adds one stall cycle.
- Timeout: DONE occurs TIMEOUT+1 cycles after the IDLE/acc cycle.
- Ack on the same cycle the counter reaches TIMEOUT-1: the ack wins and there is no `mem_err`.
- `mem_stall` is combinational from state and `acc`. All bus outputs are registered.

## Test plan

- Reset, then release:
  - Expect all outputs 0 and `mem_stall`=0 with `acc`=0.
  - Assert `reset`=0 during WAIT: `bus_req` goes 0 in the same cycle, and after release the state is IDLE.
- Load from 0x0000_1004 with `bus_ack` in the first WAIT cycle and `bus_rdata`=0xDEADBEEF:
  - `bus_addr`=0x1004, `bus_we`=0, `bus_byteen`=4'hF.
  - `mem_stall` high for exactly 2 cycles.
  - `m_data_rdata`=0xDEADBEEF in DONE.
- Store with byteen 4'b0011, wdata 0x0000_ABCD, ack after 3 wait cycles:
  - `bus_we`=1, `bus_byteen`=4'b0011, bus fields stable for 3 cycles.
  - 4 stall cycles, `mem_err`=0.
- Load with no ack, TIMEOUT=4:
  - `bus_req` drops after 4 WAIT cycles.
  - `m_data_rdata`=ERR_RDATA, `mem_err` pulses once.
  - Ack on the 4th cycle instead: no `mem_err`.
- Back-to-back load then store:
  - Two separate transactions, separated by exactly one DONE and one IDLE/acc cycle.
  - Ack with `bus_err`=1 on the store: `mem_err` pulses.
  - Spurious ack in IDLE: ignored.

Source files
------------

// File: rtl/m_data_bridge_if.sv
// Request/acknowledge data bus between the M-stage bridge and memory/peripherals.
// The bridge is the master; memory and peripherals are the slave.
interface m_data_bridge_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_byteen;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
      input  bus_ack, bus_err, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
      output bus_ack, bus_err, bus_rdata
   );
endinterface

// File: rtl/m_data_bridge.sv
// M-stage bridge: turns a single-cycle load/store into a registered bus transaction,
// stalling the pipeline until ack or timeout, then presenting read data for one cycle.
module m_data_bridge #(
   parameter int unsigned TIMEOUT   = 64,
   parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        m_data_addr,
   input  logic [3:0]         m_data_byteen,
   input  logic [31:0]        m_data_wdata,
   input  logic               m_data_ren,
   output logic [31:0]        m_data_rdata,
   output logic               mem_stall,
   output logic               mem_err,
   m_data_bridge_if.master    bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic        r_err;
   logic [31:0] r_rdata;
   logic        w_acc;
   logic        w_is_store;
   logic        w_start;
   logic        w_ack;
   logic        w_tmo;
   logic        w_unused;

   // Address bits [1:0] never reach the bus: it is word addressed.
   assign w_unused   = ^m_data_addr[1:0];
   assign w_is_store = |m_data_byteen;
   assign w_acc      = w_is_store | m_data_ren;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_ack   = 1'b0;
      w_tmo   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               w_start = 1'b1;
               w_next  = S_WAIT;
            end
         end
         S_WAIT: begin
            // An ack arriving on the last counted cycle takes priority over the timeout.
            if (bus.bus_ack) begin
               w_ack  = 1'b1;
               w_next = S_DONE;
            end else if (r_cnt == TO_LAST) begin
               w_tmo  = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign mem_stall    = reset & (((r_state == S_IDLE) & w_acc) | (r_state == S_WAIT));
   assign mem_err      = r_err;
   assign m_data_rdata = r_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.bus_req    <= 1'b0;
         bus.bus_we     <= 1'b0;
         bus.bus_addr   <= '0;
         bus.bus_byteen <= '0;
         bus.bus_wdata  <= '0;
         r_rdata        <= '0;
         r_err          <= 1'b0;
         r_cnt          <= '0;
      end else begin
         if (w_start) begin
            bus.bus_req    <= 1'b1;
            bus.bus_we     <= w_is_store;
            bus.bus_addr   <= {m_data_addr[31:2], 2'b00};
            bus.bus_byteen <= w_is_store ? m_data_byteen : 4'hF;
            bus.bus_wdata  <= m_data_wdata;
            r_cnt          <= '0;
         end
         if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
         if (w_ack) begin
            bus.bus_req <= 1'b0;
            r_err       <= bus.bus_err;
            if (!bus.bus_we) r_rdata <= bus.bus_err ? ERR_RDATA : bus.bus_rdata;
         end
         if (w_tmo) begin
            bus.bus_req <= 1'b0;
            r_rdata     <= ERR_RDATA;
            r_err       <= 1'b1;
         end
         if (r_state == S_DONE) begin
            r_err <= 1'b0;
            r_cnt <= '0;
         end
      end
   end

endmodule
